rx_prbs_checker: RTL and testbench
==================================

# rx_prbs_checker

Receive-side counterpart of the TX oversampling counter / PRBS source in the filter project. Consumes the filtered, oversampled sample stream (OS samples per symbol), picks one sample per symbol at a programmable phase, and slices it to a bit. It then self-synchronises a PRBS9 reference to the sliced bits and reports lock, bit count and error count for BER measurement.

## Interface
- NB_SAMPLE, 8: sample width, signed two's complement.
- OS, 4: oversampling factor (≥2); phase counter width NB_PH = clog2(OS).
- LOCK_COUNT, 16: consecutive correct bits required in CHECK to declare lock.
- ERR_WINDOW, 64: bits per error-monitoring window in LOCKED.
- ERR_THRESH, 8: errors within one window that drop lock.
- clock  in  1  system clock; all logic on posedge.
- i_reset  in  1  synchronous, active-high reset.
- i_enable  in  1  sample strobe; one sample per high cycle.
- i_phase  in  NB_PH  sampling phase; values ≥ OS never sample.
- i_sample  in  NB_SAMPLE  filtered sample, valid when i_enable=1.
- o_bit  out  1  sliced bit.
- o_bit_valid  out  1  one-cycle pulse per decision.
- o_locked  out  1  high in LOCKED.
- o_bit_count  out  32  bits checked while locked.
- o_err_count  out  32  bit errors while locked.

## Operation
- Phase counter ph: NB_PH bits, reset 0; on i_enable increments, wraps OS-1→0; holds when i_enable=0.
- Decision: when i_enable=1 and ph==i_phase, bit b = i_sample[NB_SAMPLE-1] (BPSK: positive→0, negative→1). i_phase change takes effect at the next strobe; a skipped phase loses that symbol, no recovery.
- PRBS9 x^9+x^5+1, register r[8:0], new bit shifted into r[0]; expected e = r[8]^r[4].
- FSM, advances only on decisions:
  - SEARCH: shift b into r; fill counter +1; at 9th fill → CHECK, good counter=0.
  - CHECK: shift b into r; b==e → good+1, reaching LOCK_COUNT → LOCKED; b!=e → SEARCH, fill=0.
  - LOCKED: shift e into r (free-running, errors do not propagate); o_bit_count+1; o_err_count+1 if b!=e; window bit/err counters advance; window err reaching ERR_THRESH → SEARCH, fill=0; window bit count reaching ERR_WINDOW → both window counters cleared (error on that same bit counts in the closing window first).
- Entering LOCKED clears o_bit_count, o_err_count and window counters. Leaving LOCKED freezes both 32-bit counters until next lock.
- 32-bit counters saturate at 0xFFFF_FFFF.
- i_enable=0: all state holds.

## Timing
- Reset values: ph=0, r=0, state SEARCH, all counters 0, o_bit=0, o_bit_valid=0, o_locked=0.
- o_bit, o_bit_valid registered: valid high exactly the cycle after the sampling edge; o_bit holds its value until the next decision.
- o_locked, o_bit_count, o_err_count update on the same edge as o_bit/o_bit_valid for that decision (visible together).
- Lock latency from SEARCH on clean data: 9 + LOCK_COUNT decisions (25 at default).
- Reset mid-operation overrides everything the same cycle; i_enable during reset is ignored.
- Throughput: up to one decision per OS strobes; back-to-back strobes (i_enable held high) supported.

## Test plan
- Reset: hold i_reset 3 cycles with i_enable=1 and random samples -> all outputs 0, no o_bit_valid; first strobe after release has ph=0.
- Phase select: OS=4, i_phase=2, i_enable continuous, samples +5,+5,-5,+5 repeating -> o_bit_valid every 4th cycle, first one cycle after the 3rd strobe, o_bit=1 each time.
- Clean lock: PRBS9 bits mapped to ±64, i_phase=0 -> o_locked rises with the 25th o_bit_valid; after 100 more decisions o_bit_count=100, o_err_count=0.
- Sparse errors: locked, flip 1 bit every 20 -> lock held; after 200 bits o_bit_count=200, o_err_count=10.
- Burst: locked, flip 8 consecutive bits -> o_locked falls on the 8th error's o_bit_valid; counters frozen; re-lock 25 decisions after clean data resumes with counters restarted at 0.
- Gaps and mid-reset: random i_enable duty 30% -> same lock/count results as continuous; i_reset pulse while locked -> o_locked=0 and counters 0 next cycle.

Source files
------------

// File: rtl/rx_prbs_checker.sv
// rx_prbs_checker: picks one sample per symbol from an oversampled stream,
// slices it to a bit (BPSK sign), self-synchronises a PRBS9 reference
// (x^9+x^5+1) to the sliced bits and keeps lock / bit / error counts.
module rx_prbs_checker #(
    parameter int NB_SAMPLE  = 8,
    parameter int OS         = 4,
    parameter int LOCK_COUNT = 16,
    parameter int ERR_WINDOW = 64,
    parameter int ERR_THRESH = 8,
    localparam int NB_PH     = (OS > 1) ? $clog2(OS) : 1
) (
    input  logic                 clock,
    input  logic                 i_reset,
    input  logic                 i_enable,
    input  logic [NB_PH-1:0]     i_phase,
    input  logic [NB_SAMPLE-1:0] i_sample,
    output logic                 o_bit,
    output logic                 o_bit_valid,
    output logic                 o_locked,
    output logic [31:0]          o_bit_count,
    output logic [31:0]          o_err_count
);

    localparam int NB_GOOD = $clog2(LOCK_COUNT + 1);
    localparam int NB_WBIT = $clog2(ERR_WINDOW + 1);
    localparam int NB_WERR = $clog2(ERR_THRESH + 1);

    localparam logic [1:0] ST_SEARCH = 2'd0;
    localparam logic [1:0] ST_CHECK  = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    localparam logic [NB_PH-1:0] PH_LAST = NB_PH'(OS - 1);

    logic [NB_PH-1:0]   ph_reg,        ph_next;
    logic [8:0]         prbs_reg,      prbs_next;
    logic [1:0]         state_reg,     state_next;
    logic [3:0]         fill_reg,      fill_next;
    logic [NB_GOOD-1:0] good_reg,      good_next;
    logic [NB_WBIT-1:0] win_bit_reg,   win_bit_next;
    logic [NB_WERR-1:0] win_err_reg,   win_err_next;
    logic [31:0]        bit_count_reg, bit_count_next;
    logic [31:0]        err_count_reg, err_count_next;
    logic               bit_reg,       bit_next;
    logic               bit_valid_reg, bit_valid_next;

    logic               hit;
    logic               sliced;
    logic               expected;
    logic               mismatch;
    logic [NB_WBIT-1:0] win_bit_inc;
    logic [NB_WERR-1:0] win_err_inc;

    // Only the sign bit matters for a BPSK decision.
    logic sample_unused;
    assign sample_unused = ^i_sample[NB_SAMPLE-2:0];

    assign hit         = i_enable && (ph_reg == i_phase);
    assign sliced      = i_sample[NB_SAMPLE-1];
    assign expected    = prbs_reg[8] ^ prbs_reg[4];
    assign mismatch    = sliced ^ expected;
    assign win_bit_inc = win_bit_reg + NB_WBIT'(1);
    assign win_err_inc = win_err_reg + NB_WERR'(mismatch);

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Next-state logic: phase counter on every strobe, FSM only on decisions.
    always_comb begin
        ph_next        = ph_reg;
        prbs_next      = prbs_reg;
        state_next     = state_reg;
        fill_next      = fill_reg;
        good_next      = good_reg;
        win_bit_next   = win_bit_reg;
        win_err_next   = win_err_reg;
        bit_count_next = bit_count_reg;
        err_count_next = err_count_reg;
        bit_next       = bit_reg;
        bit_valid_next = 1'b0;

        if (i_enable) begin
            ph_next = (ph_reg == PH_LAST) ? '0 : ph_reg + NB_PH'(1);
        end

        if (hit) begin
            bit_next       = sliced;
            bit_valid_next = 1'b1;
            case (state_reg)
                ST_SEARCH: begin
                    prbs_next = {prbs_reg[7:0], sliced};
                    fill_next = fill_reg + 4'd1;
                    // Nine bits loaded: the register now predicts the sequence.
                    if (fill_reg == 4'd8) begin
                        state_next = ST_CHECK;
                        good_next  = '0;
                    end
                end
                ST_CHECK: begin
                    prbs_next = {prbs_reg[7:0], sliced};
                    if (!mismatch) begin
                        good_next = good_reg + NB_GOOD'(1);
                        if (good_reg == NB_GOOD'(LOCK_COUNT - 1)) begin
                            state_next     = ST_LOCKED;
                            bit_count_next = '0;
                            err_count_next = '0;
                            win_bit_next   = '0;
                            win_err_next   = '0;
                        end
                    end else begin
                        state_next = ST_SEARCH;
                        fill_next  = '0;
                    end
                end
                ST_LOCKED: begin
                    // Free-running reference so received errors never corrupt it.
                    prbs_next      = {prbs_reg[7:0], expected};
                    bit_count_next = sat_inc(bit_count_reg);
                    if (mismatch) begin
                        err_count_next = sat_inc(err_count_reg);
                    end
                    win_bit_next = win_bit_inc;
                    win_err_next = win_err_inc;
                    // Threshold wins over window close so a closing-bit error still counts.
                    if (win_err_inc == NB_WERR'(ERR_THRESH)) begin
                        state_next = ST_SEARCH;
                        fill_next  = '0;
                    end else if (win_bit_inc == NB_WBIT'(ERR_WINDOW)) begin
                        win_bit_next = '0;
                        win_err_next = '0;
                    end
                end
                default: begin
                    state_next = ST_SEARCH;
                    fill_next  = '0;
                end
            endcase
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (i_reset) begin
            ph_reg        <= '0;
            prbs_reg      <= '0;
            state_reg     <= ST_SEARCH;
            fill_reg      <= '0;
            good_reg      <= '0;
            win_bit_reg   <= '0;
            win_err_reg   <= '0;
            bit_count_reg <= '0;
            err_count_reg <= '0;
            bit_reg       <= 1'b0;
            bit_valid_reg <= 1'b0;
        end else begin
            ph_reg        <= ph_next;
            prbs_reg      <= prbs_next;
            state_reg     <= state_next;
            fill_reg      <= fill_next;
            good_reg      <= good_next;
            win_bit_reg   <= win_bit_next;
            win_err_reg   <= win_err_next;
            bit_count_reg <= bit_count_next;
            err_count_reg <= err_count_next;
            bit_reg       <= bit_next;
            bit_valid_reg <= bit_valid_next;
        end
    end

    assign o_bit       = bit_reg;
    assign o_bit_valid = bit_valid_reg;
    assign o_locked    = (state_reg == ST_LOCKED);
    assign o_bit_count = bit_count_reg;
    assign o_err_count = err_count_reg;

endmodule

// File: tb/tb_rx_prbs_checker.sv
// Bench for rx_prbs_checker: behavioural model feeds a scoreboard of expected
// decisions; a negedge monitor pops and compares each o_bit_valid output.
module tb_rx_prbs_checker;

    localparam int OS         = 4;
    localparam int LOCK_COUNT = 16;
    localparam int ERR_WINDOW = 64;
    localparam int ERR_THRESH = 8;

    logic        clock = 1'b0;
    logic        i_reset;
    logic        i_enable;
    logic [1:0]  i_phase;
    logic [7:0]  i_sample;
    logic        o_bit;
    logic        o_bit_valid;
    logic        o_locked;
    logic [31:0] o_bit_count;
    logic [31:0] o_err_count;

    rx_prbs_checker #(
        .NB_SAMPLE  (8),
        .OS         (OS),
        .LOCK_COUNT (LOCK_COUNT),
        .ERR_WINDOW (ERR_WINDOW),
        .ERR_THRESH (ERR_THRESH)
    ) dut (
        .clock       (clock),
        .i_reset     (i_reset),
        .i_enable    (i_enable),
        .i_phase     (i_phase),
        .i_sample    (i_sample),
        .o_bit       (o_bit),
        .o_bit_valid (o_bit_valid),
        .o_locked    (o_locked),
        .o_bit_count (o_bit_count),
        .o_err_count (o_err_count)
    );

    always #5 clock = ~clock;

    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    typedef struct {
        int unsigned cyc;
        logic        b;
        logic        lk;
        logic [31:0] bc;
        logic [31:0] ec;
    } exp_t;

    exp_t sb[$];

    // Behavioural reference state
    int          m_ph, m_st, m_fill, m_good, m_wb, m_we;
    int unsigned m_bc, m_ec;
    logic [8:0]  m_r;

    task automatic model_reset();
        m_ph = 0; m_st = 0; m_fill = 0; m_good = 0;
        m_wb = 0; m_we = 0; m_bc = 0; m_ec = 0; m_r = '0;
    endtask

    task automatic model_strobe(input logic [7:0] s);
        exp_t ex;
        logic b, e;
        bit   hit;
        hit  = (m_ph == int'(i_phase));
        m_ph = (m_ph + 1) % OS;
        if (!hit) return;
        b = s[7];
        e = m_r[8] ^ m_r[4];
        case (m_st)
            0: begin
                m_r = {m_r[7:0], b};
                m_fill++;
                if (m_fill == 9) begin m_st = 1; m_good = 0; end
            end
            1: begin
                m_r = {m_r[7:0], b};
                if (b == e) begin
                    m_good++;
                    if (m_good == LOCK_COUNT) begin
                        m_st = 2; m_bc = 0; m_ec = 0; m_wb = 0; m_we = 0;
                    end
                end else begin
                    m_st = 0; m_fill = 0;
                end
            end
            default: begin
                m_r = {m_r[7:0], e};
                m_bc++;
                m_wb++;
                if (b != e) begin m_ec++; m_we++; end
                if (m_we == ERR_THRESH) begin
                    m_st = 0; m_fill = 0;
                end else if (m_wb == ERR_WINDOW) begin
                    m_wb = 0; m_we = 0;
                end
            end
        endcase
        ex.cyc = cyc + 1;
        ex.b   = b;
        ex.lk  = (m_st == 2);
        ex.bc  = m_bc;
        ex.ec  = m_ec;
        sb.push_back(ex);
    endtask

    // Monitor: one line per decision, compared against the scoreboard
    int valid_idx = 0;
    int rise_idx  = 0;
    int fall_idx  = 0;
    logic prev_locked = 1'b0;

    always @(negedge clock) begin : monitor
        exp_t ex;
        if (o_bit_valid) begin
            valid_idx++;
            if (o_locked && !prev_locked) rise_idx = valid_idx;
            if (!o_locked && prev_locked) fall_idx = valid_idx;
            if (sb.size() == 0) begin
                check_eq("spurious_valid", 32'(o_bit_valid), 32'd0);
            end else begin
                ex = sb.pop_front();
                $display("dec %0d cyc=%0d bit=%0b locked=%0b bits=%0d errs=%0d",
                         valid_idx, cyc, o_bit, o_locked, o_bit_count, o_err_count);
                check_eq("dec_cycle", 32'(cyc), 32'(ex.cyc));
                check_eq("dec_bit", 32'(o_bit), 32'(ex.b));
                check_eq("dec_locked", 32'(o_locked), 32'(ex.lk));
                check_eq("dec_bit_count", o_bit_count, ex.bc);
                check_eq("dec_err_count", o_err_count, ex.ec);
            end
        end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
            check_eq("missing_valid", 32'(o_bit_valid), 32'd1);
            void'(sb.pop_front());
        end
        prev_locked = o_locked;
    end

    // Stimulus helpers
    bit         gap_mode = 1'b0;
    logic [8:0] gen = 9'h1FF;

    task automatic drive(input logic en, input logic [7:0] s);
        @(negedge clock);
        i_reset  = 1'b0;
        i_enable = en;
        i_sample = s;
        if (en) model_strobe(s);
    endtask

    task automatic do_reset(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clock);
            i_reset  = 1'b1;
            i_enable = 1'b1;
            i_sample = 8'($urandom);
            model_reset();
        end
    endtask

    task automatic send_bit(input bit flip);
        logic       b;
        logic [7:0] v;
        b   = gen[8] ^ gen[4];
        gen = {gen[7:0], b};
        v   = (b ^ flip) ? 8'hC0 : 8'h40;
        for (int p = 0; p < OS; p++) begin
            if (gap_mode) begin
                for (int g = 0; g < 20 && $urandom_range(0, 99) >= 30; g++)
                    drive(1'b0, 8'($urandom));
            end
            drive(1'b1, (p == 0) ? v : 8'($urandom));
        end
    endtask

    task automatic send_clean(input int n);
        for (int k = 0; k < n; k++) send_bit(1'b0);
    endtask

    int base;

    initial begin
        i_reset  = 1'b1;
        i_enable = 1'b0;
        i_phase  = 2'd0;
        i_sample = 8'd0;
        model_reset();

        // Reset held with strobes active
        do_reset(3);
        drive(1'b0, 8'd0);
        check_eq("rst_bit", 32'(o_bit), 32'd0);
        check_eq("rst_valid", 32'(o_bit_valid), 32'd0);
        check_eq("rst_locked", 32'(o_locked), 32'd0);
        check_eq("rst_bit_count", o_bit_count, 32'd0);
        check_eq("rst_err_count", o_err_count, 32'd0);

        // Phase select: decision on every 4th strobe, one cycle after phase 2
        i_phase = 2'd2;
        for (int k = 0; k < 16; k++) begin
            drive(1'b1, (k % 4 == 2) ? 8'hFB : 8'h05);
            check_eq("phase_valid", 32'(o_bit_valid), 32'((k % 4) == 3));
        end
        drive(1'b0, 8'd0);
        check_eq("phase_bit_hold", 32'(o_bit), 32'd1);

        // Clean lock at phase 0
        i_phase = 2'd0;
        do_reset(1);
        drive(1'b0, 8'd0);
        base = valid_idx;
        send_clean(24);
        check_eq("lock_not_yet", 32'(o_locked), 32'd0);
        send_clean(1);
        check_eq("lock_rise", 32'(o_locked), 32'd1);
        check_eq("lock_rise_idx", 32'(rise_idx), 32'(base + 25));
        send_clean(100);
        check_eq("clean_bit_count", o_bit_count, 32'd100);
        check_eq("clean_err_count", o_err_count, 32'd0);

        // Sparse errors: one flip every 20 bits keeps lock
        do_reset(1);
        drive(1'b0, 8'd0);
        send_clean(25);
        for (int n = 1; n <= 200; n++) send_bit(n % 20 == 0);
        check_eq("sparse_locked", 32'(o_locked), 32'd1);
        check_eq("sparse_bit_count", o_bit_count, 32'd200);
        check_eq("sparse_err_count", o_err_count, 32'd10);
        send_clean(56);
        check_eq("window_bit_count", o_bit_count, 32'd256);

        // Burst of 8 errors in a fresh window drops lock on the 8th
        base = valid_idx;
        for (int n = 0; n < 8; n++) send_bit(1'b1);
        check_eq("burst_fall_idx", 32'(fall_idx), 32'(base + 8));
        check_eq("burst_unlocked", 32'(o_locked), 32'd0);
        check_eq("burst_bit_count", o_bit_count, 32'd264);
        check_eq("burst_err_count", o_err_count, 32'd18);
        base = valid_idx;
        send_clean(24);
        check_eq("frozen_locked", 32'(o_locked), 32'd0);
        check_eq("frozen_bit_count", o_bit_count, 32'd264);
        check_eq("frozen_err_count", o_err_count, 32'd18);
        send_clean(1);
        check_eq("relock", 32'(o_locked), 32'd1);
        check_eq("relock_idx", 32'(rise_idx), 32'(base + 25));
        check_eq("relock_bit_count", o_bit_count, 32'd0);
        check_eq("relock_err_count", o_err_count, 32'd0);

        // Gapped strobes give the same results
        gap_mode = 1'b1;
        do_reset(1);
        drive(1'b0, 8'd0);
        base = valid_idx;
        send_clean(25);
        check_eq("gap_lock_idx", 32'(rise_idx), 32'(base + 25));
        send_clean(100);
        check_eq("gap_bit_count", o_bit_count, 32'd100);
        check_eq("gap_err_count", o_err_count, 32'd0);

        // Reset pulse while locked
        do_reset(1);
        drive(1'b0, 8'd0);
        check_eq("midrst_locked", 32'(o_locked), 32'd0);
        check_eq("midrst_bit_count", o_bit_count, 32'd0);
        check_eq("midrst_err_count", o_err_count, 32'd0);
        gap_mode = 1'b0;

        for (int k = 0; k < 5; k++) drive(1'b0, 8'd0);
        check_eq("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
